// File: rtl/resto_mod_seq_if.sv
// Handshake and data bundle for the bit-serial remainder/quotient unit.
// The master side requests divisions; the slave side is the divider itself.
interface resto_mod_seq_if #(
   parameter int W  = 4,
   parameter int M  = 5,
   parameter int RW = $clog2(M)
);
   logic          start;
   logic [W-1:0]  sensor;
   logic          busy;
   logic          done;
   logic [RW-1:0] resto;
   logic [W-1:0]  quociente;

   modport master (
      output start, sensor,
      input  busy, done, resto, quociente
   );

   modport slave (
      input  start, sensor,
      output busy, done, resto, quociente
   );
endinterface

// File: rtl/resto_mod_seq.sv
// Restoring division of a W-bit sensor word by the constant M, one quotient bit
// per clock, MSB first; results are held until the next completed division.
module resto_mod_seq #(
   parameter int W  = 4,
   parameter int M  = 5,
   parameter int RW = $clog2(M),
   parameter int CW = $clog2(W + 1)
) (
   input  logic           clk,
   input  logic           rst,
   resto_mod_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [RW:0] MV = (RW + 1)'(M);

   state_t        state, state_next;
   logic [W-1:0]  sreg;
   logic [RW-1:0] r;
   logic [W-1:0]  qreg;
   logic [CW-1:0] cnt;
   logic [RW-1:0] resto_q;
   logic [W-1:0]  quoc_q;

   logic          accept;
   logic          last;
   logic [RW:0]   t;
   logic [RW:0]   diff;
   logic          qbit;
   logic [RW-1:0] r_step;
   logic [W-1:0]  q_step;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Since r < M, t < 2M, so one conditional subtract yields the exact step.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      t          = {r, sreg[W-1]};
      diff       = t - MV;
      qbit       = (t >= MV);
      r_step     = qbit ? diff[RW-1:0] : t[RW-1:0];
      q_step     = {qreg[W-2:0], qbit};
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CW'(1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg    <= '0;
         r       <= '0;
         qreg    <= '0;
         cnt     <= '0;
         resto_q <= '0;
         quoc_q  <= '0;
      end else if (accept) begin
         sreg <= bus.sensor;
         r    <= '0;
         qreg <= '0;
         cnt  <= CW'(W);
      end else if (state == SHIFT) begin
         sreg <= {sreg[W-2:0], 1'b0};
         r    <= r_step;
         qreg <= q_step;
         cnt  <= cnt - CW'(1);
         if (last) begin
            resto_q <= r_step;
            quoc_q  <= q_step;
         end
      end
   end

   assign bus.busy      = (state == SHIFT);
   assign bus.done      = (state == DONE);
   assign bus.resto     = resto_q;
   assign bus.quociente = quoc_q;

endmodule

// File: doc/resto_mod_seq.md
# resto_mod_seq

Sequential, parametrised remainder/quotient unit: divides a W-bit `sensor` word by a constant modulus M using bit-serial restoring division, MSB first, one bit per clock. It supersedes the fixed 4-bit combinational mod-5 detector. It adds a generic width and modulus, a quotient output, and a start/busy/done handshake, so it can run in clocked sensor pipelines.

## Interface
- `W`, default 4: input word width, W ≥ 2.
- `M`, default 5: divisor constant, 2 ≤ M ≤ 2^W − 1.
- `RW`, default `$clog2(M)`: remainder width (derived; do not override).
- `CW`, default `$clog2(W+1)`: bit-counter width (derived).

Ports:
- `clk`  in  1: single clock, all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request a new division; sampled on the rising edge.
- `sensor`  in  W: dividend; sampled only on the edge that accepts `start`.
- `busy`  out  1: high while a division is in progress (SHIFT state).
- `done`  out  1: single-cycle pulse; `resto` and `quociente` were updated on the same edge.
- `resto`  out  RW: `sensor mod M` of the last completed division.
- `quociente`  out  W: `sensor / M` (floor) of the last completed division.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE, `start`=1: capture `sensor` into the shift register, clear the working remainder r, set counter = W, go to SHIFT.
- IDLE, `start`=0: stay in IDLE.
- SHIFT, each cycle:
  - b = MSB of shift register; t = {r, b} (RW+1 bits).
  - If t ≥ M: r ← t − M and q-bit = 1; else r ← t and q-bit = 0.
  - Shift the q-bit into the quotient shift register from the LSB side.
  - Decrement the counter.
- SHIFT exit: when the counter reaches 1, the current step is the last one. On that edge, load the final r into `resto` and the final quotient into `quociente`, go to DONE.
- Because r < M always, t < 2M. A single conditional subtract is therefore exact; no other arithmetic is required.
- DONE: `done`=1 for exactly this cycle.
  - `start`=1 in DONE: accepted exactly as in IDLE (back-to-back operation), go to SHIFT.
  - Otherwise go to IDLE.
- `start` while in SHIFT is ignored. It is not queued, and `sensor` changes during SHIFT have no effect.
- `resto` and `quociente` change only on the completion edge. They hold their value through IDLE and through subsequent SHIFT phases until the next completion.
- `rst`=1 on any edge, including mid-SHIFT or coincident with `start`:
  - state ← IDLE; `busy`, `done`, `resto`, `quociente`, counter and internal registers ← 0.
  - The in-flight operation is discarded; `rst` has priority over `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `resto`=0, `quociente`=0.
- `start` accepted at edge k:
  - `busy`=1 from edge k to edge k+W (W cycles).
  - Results and `done`=1 appear at edge k+W; `done` drops at edge k+W+1.
- Latency from the accepting edge to valid results is W cycles. Back-to-back throughput is one result per W+1 cycles.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- W=4, M=5, sequential starts of 0110, 1101, 1010, 0011, 1001 -> `resto` = 1, 3, 0, 3, 4 and `quociente` = 1, 2, 2, 0, 1; each `done` pulse arrives exactly 4 cycles after its `start`.
- W=4, M=5 boundary values: 0000 -> resto 0, quociente 0; 1111 -> resto 0, quociente 3; 0100 (< M) -> resto 4, quociente 0.
- W=8, M=7: 8'hFF -> resto 3, quociente 36; 8'h07 -> resto 0, quociente 1; `done` arrives 8 cycles after `start`.
- Handshake, W=4, M=5:
  - `start` pulses on cycles 2 and 3 of a SHIFT phase are ignored, and `sensor` is changed mid-SHIFT; the result still reflects the captured word.
  - `start` held high in the DONE cycle begins the next division immediately, with no IDLE cycle.
- Reset mid-operation: assert `rst` on the 2nd SHIFT cycle -> next cycle all outputs 0, state IDLE, no `done`. A following `start` with 1101 -> resto 3.
- Reset concurrent with `start`: `rst`=1 and `start`=1 on the same edge -> stays IDLE, `busy`=0; previously held `resto` and `quociente` are cleared to 0.
